// File: rtl/sum_window_acc.sv
// Windowed accumulator: sums WINDOW upstream samples and presents the total through a valid/ready output stage.
// Optional macro SUM_WINDOW_ACC_SAT_EN: clamp the accumulator on overflow instead of wrapping.
module sum_window_acc #(
  parameter int WINDOW = 4,
  parameter int ACC_W  = 7
) (
  input  logic             tb_clk,
  input  logic             tb_rst,
  input  logic [4:0]       sum_in,
  input  logic             sum_valid,
  output logic             sum_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  // Handshake rule for both ports: a transfer happens on a rising edge exactly
  // when valid && ready are both high; neither side may depend on the transfer
  // of the same cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  localparam logic [7:0]       WIN     = 8'(WINDOW);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] acc_add;
  logic             xfer_in;
  logic             xfer_out;

  assign sum_ready = (state_q != HOLD);
  assign xfer_in   = sum_valid && sum_ready;
  assign xfer_out  = valid_q && acc_ready;

  // One extra bit so the carry out of the accumulator is visible.
  assign sum_ext = {1'b0, acc_q} + (ACC_W+1)'(sum_in);
  assign carry   = sum_ext[ACC_W];

`ifdef SUM_WINDOW_ACC_SAT_EN
  // Once the window has overflowed it stays pinned at the maximum.
  assign acc_add = (carry || ovf_q) ? ACC_MAX : sum_ext[ACC_W-1:0];
`else
  assign acc_add = sum_ext[ACC_W-1:0];
`endif

  always_ff @(posedge tb_clk or posedge tb_rst) begin
    if (tb_rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (xfer_in) begin
          acc_d = ACC_W'(sum_in);
          cnt_d = 8'd1;
          ovf_d = 1'b0;
          if (WIN == 8'd1) begin
            state_d = HOLD;
            valid_d = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (xfer_in) begin
          acc_d = acc_add;
          cnt_d = cnt_q + 8'd1;
          ovf_d = ovf_q | carry;
          if (cnt_q + 8'd1 == WIN) begin
            state_d = HOLD;
            valid_d = 1'b1;
          end
        end
      end
      HOLD: begin
        // Result is frozen until the consumer takes it; then start clean.
        if (xfer_out) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign acc_out   = acc_q;
  assign acc_valid = valid_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sum_window_acc.sv
// Bench for sum_window_acc: three instances (WINDOW/ACC_W = 4/7, 16/8, 1/5) under directed and random traffic.
// A sample-list reference model feeds an expected-result queue per instance; a negedge monitor checks.
module tb_sum_window_acc;

  localparam int W0 = 4,  A0 = 7;
  localparam int W1 = 16, A1 = 8;
  localparam int W2 = 1,  A2 = 5;

  logic            tb_clk = 1'b0;
  logic            tb_rst;
  logic [2:0][4:0] sum_in;
  logic [2:0]      sum_valid;
  logic [2:0]      acc_ready;
  logic [2:0]      sum_ready;
  logic [2:0]      acc_valid;
  logic [2:0]      ovf;
  logic [A0-1:0]   acc_out0;
  logic [A1-1:0]   acc_out1;
  logic [A2-1:0]   acc_out2;
  logic [1:0]      dbg0, dbg1, dbg2;

  int checks = 0;
  int failures = 0;
  bit end_flag = 1'b0;
  bit end_done = 1'b0;

  // clock / reset
  always #5 tb_clk = ~tb_clk;

  sum_window_acc #(.WINDOW(W0), .ACC_W(A0)) u_dut0 (
    .tb_clk(tb_clk), .tb_rst(tb_rst), .sum_in(sum_in[0]), .sum_valid(sum_valid[0]),
    .sum_ready(sum_ready[0]), .acc_out(acc_out0), .acc_valid(acc_valid[0]),
    .acc_ready(acc_ready[0]), .ovf(ovf[0]), .dbg_state(dbg0));
  sum_window_acc #(.WINDOW(W1), .ACC_W(A1)) u_dut1 (
    .tb_clk(tb_clk), .tb_rst(tb_rst), .sum_in(sum_in[1]), .sum_valid(sum_valid[1]),
    .sum_ready(sum_ready[1]), .acc_out(acc_out1), .acc_valid(acc_valid[1]),
    .acc_ready(acc_ready[1]), .ovf(ovf[1]), .dbg_state(dbg1));
  sum_window_acc #(.WINDOW(W2), .ACC_W(A2)) u_dut2 (
    .tb_clk(tb_clk), .tb_rst(tb_rst), .sum_in(sum_in[2]), .sum_valid(sum_valid[2]),
    .sum_ready(sum_ready[2]), .acc_out(acc_out2), .acc_valid(acc_valid[2]),
    .acc_ready(acc_ready[2]), .ovf(ovf[2]), .dbg_state(dbg2));

  // scoreboard storage: {ovf, result}
  logic [16:0] exp_q0[$];
  logic [16:0] exp_q1[$];
  logic [16:0] exp_q2[$];

  function automatic int win_of(int i);
    case (i)
      0: return W0;
      1: return W1;
      default: return W2;
    endcase
  endfunction

  function automatic int accw_of(int i);
    case (i)
      0: return A0;
      1: return A1;
      default: return A2;
    endcase
  endfunction

  function automatic int acc_out_of(int i);
    case (i)
      0: return int'(acc_out0);
      1: return int'(acc_out1);
      default: return int'(acc_out2);
    endcase
  endfunction

  // Reference value of the accumulator for a plain integer running total.
  function automatic int exp_acc(int total, int accw);
    int max_v;
    max_v = (1 << accw) - 1;
`ifdef SUM_WINDOW_ACC_SAT_EN
    return (total > max_v) ? max_v : total;
`else
    return total % (1 << accw);
`endif
  endfunction

  function automatic int q_size(int i);
    case (i)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [16:0] q_front(int i);
    case (i)
      0: return exp_q0[0];
      1: return exp_q1[0];
      default: return exp_q2[0];
    endcase
  endfunction

  task automatic q_push(input int i, input logic [16:0] v);
    case (i)
      0: exp_q0.push_back(v);
      1: exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  task automatic q_pop(input int i);
    case (i)
      0: void'(exp_q0.pop_front());
      1: void'(exp_q1.pop_front());
      default: void'(exp_q2.pop_front());
    endcase
  endtask

  task automatic q_clear(input int i);
    case (i)
      0: exp_q0.delete();
      1: exp_q1.delete();
      default: exp_q2.delete();
    endcase
  endtask

  task automatic chk(input string name, input int i, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s inst%0d t=%0t got=%0d expected=%0d", name, i, $time, act, expv);
    end
  endtask

  // reference model state: samples taken so far and their plain sum
  int m_cnt[3];
  int m_total[3];
  bit m_hold[3];
  logic [16:0] e;

  // monitor: compare, then advance the model with the inputs for the next edge
  always @(negedge tb_clk) begin
    for (int i = 0; i < 3; i++) begin
      if (tb_rst) begin
        m_cnt[i] = 0;
        m_total[i] = 0;
        m_hold[i] = 1'b0;
        q_clear(i);
        chk("rst_valid", i, int'(acc_valid[i]), 0);
        chk("rst_acc", i, acc_out_of(i), 0);
        chk("rst_ovf", i, int'(ovf[i]), 0);
      end else begin
        chk("sum_ready", i, int'(sum_ready[i]), int'(!m_hold[i]));
        chk("acc_valid", i, int'(acc_valid[i]), int'(m_hold[i]));
        if (acc_valid[i]) begin
          chk("result_pending", i, int'(q_size(i) > 0), 1);
          if (q_size(i) > 0) begin
            e = q_front(i);
            chk("acc_out", i, acc_out_of(i), int'(e[15:0]));
            chk("ovf_out", i, int'(ovf[i]), int'(e[16]));
            if (acc_ready[i]) q_pop(i);
          end
        end else begin
          chk("run_acc", i, acc_out_of(i), exp_acc(m_total[i], accw_of(i)));
          chk("run_ovf", i, int'(ovf[i]), int'(m_total[i] > (1 << accw_of(i)) - 1));
        end
        if (m_hold[i]) begin
          if (acc_ready[i]) begin
            m_hold[i] = 1'b0;
            m_cnt[i] = 0;
            m_total[i] = 0;
          end
        end else if (sum_valid[i]) begin
          m_total[i] += int'(sum_in[i]);
          m_cnt[i]++;
          if (m_cnt[i] == win_of(i)) begin
            m_hold[i] = 1'b1;
            q_push(i, {m_total[i] > (1 << accw_of(i)) - 1,
                       16'(exp_acc(m_total[i], accw_of(i)))});
          end
        end
      end
    end
    if (end_flag && !end_done) begin
      end_done = 1'b1;
      for (int i = 0; i < 3; i++) chk("drained", i, q_size(i), 0);
    end
  end

  // driver tasks
  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic drive(input int i, input bit v, input logic [4:0] s, input bit r);
    sum_valid[i] = v;
    sum_in[i] = s;
    acc_ready[i] = r;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 5'($urandom_range(0, 31)), 1'b1);
  endtask

  task automatic do_reset(input int cycles);
    tb_rst = 1'b1;
    repeat (cycles) step();
    tb_rst = 1'b0;
  endtask

  initial begin
    logic [4:0] seq_a[4];
    bit pat[7];
    seq_a = '{5'd10, 5'd20, 5'd30, 5'd31};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tb_rst = 1'b1;
    sum_valid = '0;
    acc_ready = '0;
    sum_in = '0;
    repeat (3) step();
    tb_rst = 1'b0;
    idle_all();
    step();

    // back-to-back window, consumer always ready
    for (int k = 0; k < 4; k++) begin drive(0, 1'b1, seq_a[k], 1'b1); step(); end
    drive(0, 1'b0, 5'd0, 1'b1);
    repeat (3) step();

    // consumer stalls in HOLD while upstream keeps offering 7
    for (int k = 0; k < 4; k++) begin drive(0, 1'b1, seq_a[k], 1'b0); step(); end
    drive(0, 1'b1, 5'd7, 1'b0);
    repeat (3) step();
    drive(0, 1'b1, 5'd7, 1'b1);
    repeat (2) step();
    drive(0, 1'b0, 5'd0, 1'b1);
    step();

    // gapped input, garbage on idle cycles
    do_reset(2);
    for (int k = 0; k < 7; k++) begin
      drive(0, pat[k], pat[k] ? 5'd5 : 5'($urandom_range(0, 31)), 1'b1);
      step();
    end
    drive(0, 1'b0, 5'd0, 1'b1);
    repeat (3) step();

    // sixteen maximum samples overflow the 8-bit accumulator
    for (int k = 0; k < 16; k++) begin drive(1, 1'b1, 5'd31, 1'b1); step(); end
    drive(1, 1'b0, 5'd0, 1'b1);
    repeat (3) step();

    // reset in the middle of a window, then a fresh window
    drive(0, 1'b1, 5'd9, 1'b1); step();
    drive(0, 1'b1, 5'd9, 1'b1); step();
    do_reset(2);
    for (int k = 1; k <= 4; k++) begin drive(0, 1'b1, 5'(k), 1'b1); step(); end
    drive(0, 1'b0, 5'd0, 1'b1);
    repeat (3) step();

    // single-sample window with a continuously offered sample
    drive(2, 1'b1, 5'd17, 1'b1);
    repeat (6) step();
    drive(2, 1'b0, 5'd0, 1'b1);
    step();

    // random traffic with occasional resets
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 3; i++)
        drive(i, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom_range(0, 2) != 0);
      if ($urandom_range(0, 499) == 0) do_reset(1 + $urandom_range(0, 2));
      else step();
    end

    idle_all();
    repeat (5) step();
    end_flag = 1'b1;
    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
